// File: rtl/stream_pkg.sv
// stream_pkg: shared stream width constants and width helpers
package stream_pkg;
  localparam int DATA_W_DEF = 32;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int tag_width(input int n);
    return (clog2(n) > 1) ? clog2(n) : 1;
  endfunction
endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: power-of-two synchronous FIFO with vld/ack on both sides and registered full/empty
module stream_fifo
  import stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_vld,
  output logic              wr_ack,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_vld,
  input  logic              rd_ack,
  output logic [DATA_W-1:0] rd_data
);
  localparam int AW = clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt, cnt_nxt;
  logic full, empty, wr, rd;
  assign wr_ack = !full;
  assign rd_vld = !empty;
  assign wr = wr_vld & !full;
  assign rd = rd_ack & !empty;
  assign cnt_nxt = cnt + CW'(wr) - CW'(rd);
  assign rd_data = mem[rp];
  always_ff @(posedge clk)
    if (wr) mem[wp] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (rd) rp <= rp + AW'(1);
      cnt <= cnt_nxt;
      full <= cnt_nxt == CW'(FIFO_DEPTH);
      empty <= cnt_nxt == '0;
    end
endmodule

// File: rtl/stream_rr_mux.sv
// stream_rr_mux: N-to-1 round-robin stream concentrator, output tagged with source channel.
// Define STREAM_RR_MUX_PKT_LOCK_EN to hold the grant until a word with payload MSB (last) set.
module stream_rr_mux
  import stream_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4,
  localparam int TAG_W = tag_width(NUM_CH)
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     ap_start,
  output logic                     ap_idle,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_vld,
  output logic [NUM_CH-1:0]        in_ack,
  output logic [TAG_W+DATA_W-1:0] out_data,
  output logic                     out_vld,
  input  logic                     out_ack
);
  logic [1:0] rst_sync;
  logic rst_n, gnt_vld, load;
  logic [NUM_CH-1:0] wr_ack, not_empty, rd_ack, wr;
  logic [DATA_W-1:0] rd_data [NUM_CH];
  logic [TAG_W-1:0] rr_ptr, gnt, idx;
`ifdef STREAM_RR_MUX_PKT_LOCK_EN
  logic locked;
  logic [TAG_W-1:0] lock_ch;
`endif

  function automatic logic [TAG_W-1:0] wrap_inc(input logic [TAG_W-1:0] v);
    return (v == TAG_W'(NUM_CH - 1)) ? '0 : v + TAG_W'(1);
  endfunction

  // asynchronous assertion, synchronous release
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];

  assign in_ack = {NUM_CH{ap_start & rst_n}} & wr_ack;
  assign wr = in_vld & in_ack;
  assign load = gnt_vld & (!out_vld | out_ack);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    stream_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(ap_clk),
      .rst_n(rst_n),
      .wr_vld(wr[c]),
      .wr_ack(wr_ack[c]),
      .wr_data(in_data[c*DATA_W +: DATA_W]),
      .rd_vld(not_empty[c]),
      .rd_ack(rd_ack[c]),
      .rd_data(rd_data[c])
    );
    assign rd_ack[c] = load && gnt == TAG_W'(c);
  end

  // first non-empty channel at or after rr_ptr, wrapping
  always_comb begin
    gnt_vld = 1'b0;
    gnt = rr_ptr;
    idx = rr_ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!gnt_vld && not_empty[idx]) begin
        gnt_vld = 1'b1;
        gnt = idx;
      end
      idx = wrap_inc(idx);
    end
`ifdef STREAM_RR_MUX_PKT_LOCK_EN
    if (locked) begin
      gnt = lock_ch;
      gnt_vld = not_empty[lock_ch];
    end
`endif
  end

  always_ff @(posedge ap_clk or negedge rst_n)
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_data <= '0;
      rr_ptr <= '0;
      ap_idle <= 1'b1;
`ifdef STREAM_RR_MUX_PKT_LOCK_EN
      locked <= 1'b0;
      lock_ch <= '0;
`endif
    end else begin
      ap_idle <= !(|not_empty) && !out_vld && !(|wr);
      if (load) begin
        out_vld <= 1'b1;
        out_data <= {gnt, rd_data[gnt]};
`ifdef STREAM_RR_MUX_PKT_LOCK_EN
        locked <= !rd_data[gnt][DATA_W-1];
        lock_ch <= gnt;
        if (rd_data[gnt][DATA_W-1]) rr_ptr <= wrap_inc(gnt);
`else
        rr_ptr <= wrap_inc(gnt);
`endif
      end else if (out_ack) out_vld <= 1'b0;
    end
endmodule

// File: tb/tb_stream_rr_mux.sv
// tb_stream_rr_mux: vector table plus scoreboarded sequences for stream_rr_mux
module tb_stream_rr_mux;
  localparam int N = 4;
  localparam int W = 32;
  typedef struct {
    int ch;
    logic [W-1:0] d;
    logic [W+1:0] exp;
  } vec_t;

  logic ap_clk = 1'b0;
  logic ap_rst_n, ap_start, ap_idle, out_vld, out_ack;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_vld, in_ack;
  logic [W+1:0] out_data;
  logic [W+1:0] sb_q[$];
  vec_t tbl[5];
  int cnt[N];
  int checks = 0;
  int errors = 0;

  stream_rr_mux dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .ap_start(ap_start),
    .ap_idle(ap_idle),
    .in_data(in_data),
    .in_vld(in_vld),
    .in_ack(in_ack),
    .out_data(out_data),
    .out_vld(out_vld),
    .out_ack(out_ack)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  function automatic logic [W-1:0] fdat(int c, int k);
    return 32'h8000_0000 | (32'(c) << 8) | 32'(k);
  endfunction

  // keep every channel streaming, advancing each channel's data on acceptance
  task automatic tick();
    logic [N-1:0] acc;
    acc = in_vld & in_ack;
    step();
    for (int c = 0; c < N; c++)
      if (acc[c]) begin
        cnt[c]++;
        in_data[c*W +: W] = fdat(c, cnt[c]);
      end
  endtask

  task automatic send(int ch, logic [W-1:0] d, bit push);
    int n;
    n = 0;
    in_data[ch*W +: W] = d;
    in_vld[ch] = 1'b1;
    while (!in_ack[ch] && n < 20) begin
      step();
      n++;
    end
    if (!in_ack[ch]) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ch%0d in_ack stuck at 0, need 1", ch);
    end
    if (push) sb_q.push_back({2'(ch), d});
    step();
    in_vld[ch] = 1'b0;
  endtask

  task automatic wait_ready(string name, int bound);
    for (int i = 0; i < bound && in_ack !== 4'hF; i++) step();
    chk(name, in_ack, 4'hF);
  endtask

  always @(negedge ap_clk)
    if (out_vld === 1'b1 && out_ack === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: got %h expected no word", out_data);
      end else chk("sb_order", out_data, sb_q.pop_front());
    end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 32'hDEAD_BEEF, {2'd0, 32'hDEAD_BEEF}};
    tbl[1] = '{3, 32'hFFFF_FFFF, {2'd3, 32'hFFFF_FFFF}};
    tbl[2] = '{2, 32'h8000_0000, {2'd2, 32'h8000_0000}};
    tbl[3] = '{3, 32'h8000_0001, {2'd3, 32'h8000_0001}};
    tbl[4] = '{1, 32'hC3C3_3C3C, {2'd1, 32'hC3C3_3C3C}};
    ap_rst_n = 1'b0;
    ap_start = 1'b1;
    out_ack = 1'b1;
    in_vld = '0;
    in_data = '0;
    repeat (3) step();
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ack", in_ack, 0);
    chk("rst_idle", ap_idle, 1);
    ap_rst_n = 1'b1;
    #1;
    chk("rel_in_ack_low", in_ack, 0);
    wait_ready("rel_in_ack", 2);

    // fairness: all channels kept full, rr_ptr starts at 0
    out_ack = 1'b0;
    for (int c = 0; c < N; c++) begin
      cnt[c] = 0;
      in_data[c*W +: W] = fdat(c, 0);
    end
    in_vld = '1;
    repeat (6) tick();
    chk("fair_full_ack", in_ack, 0);
    chk("fair_head", out_data, {2'd0, fdat(0, 0)});
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < N; c++) sb_q.push_back({2'(c), fdat(c, k)});
    out_ack = 1'b1;
    repeat (16) tick();
    out_ack = 1'b0;
    in_vld = '0;
    chk("fair_count", sb_q.size(), 0);

    // reset with buffered words
    ap_rst_n = 1'b0;
    #1;
    chk("mid_rst_out_vld", out_vld, 0);
    chk("mid_rst_in_ack", in_ack, 0);
    chk("mid_rst_idle", ap_idle, 1);
    repeat (2) step();
    ap_rst_n = 1'b1;
    wait_ready("mid_rst_ready", 3);
    out_ack = 1'b1;
    repeat (3) step();
    chk("mid_rst_empty", out_vld, 0);
    chk("mid_rst_idle2", ap_idle, 1);

    foreach (tbl[i]) begin
      send(tbl[i].ch, tbl[i].d, 1'b1);
      chk("tbl_latency", out_vld, 0);
      step();
      chk("tbl_vld", out_vld, 1);
      chk("tbl_data", out_data, tbl[i].exp);
      repeat (2) step();
      chk("tbl_idle", ap_idle, 1);
    end

    // wrap/skip: last grant was ch1, so rr_ptr=2
    out_ack = 1'b0;
    in_data[1*W +: W] = 32'h9000_0010;
    in_data[3*W +: W] = 32'h9000_0030;
    in_vld = 4'b1010;
    step();
    in_data[1*W +: W] = 32'h9000_0011;
    in_data[3*W +: W] = 32'h9000_0031;
    step();
    in_vld = '0;
    chk("wrap_first", out_data, {2'd3, 32'h9000_0030});
    sb_q.push_back({2'd3, 32'h9000_0030});
    sb_q.push_back({2'd1, 32'h9000_0010});
    sb_q.push_back({2'd3, 32'h9000_0031});
    sb_q.push_back({2'd1, 32'h9000_0011});
    out_ack = 1'b1;
    repeat (5) step();
    chk("wrap_count", sb_q.size(), 0);

    // single channel back-to-back
    for (int i = 1; i <= 3; i++) sb_q.push_back({2'd2, 32'hA5A5_0000 | 32'(i)});
    in_vld[2] = 1'b1;
    in_data[2*W +: W] = 32'hA5A5_0001;
    step();
    chk("single_lat", out_vld, 0);
    in_data[2*W +: W] = 32'hA5A5_0002;
    step();
    chk("single_w1", out_data, {2'd2, 32'hA5A5_0001});
    in_data[2*W +: W] = 32'hA5A5_0003;
    step();
    chk("single_w2", out_data, {2'd2, 32'hA5A5_0002});
    in_vld[2] = 1'b0;
    step();
    chk("single_w3", out_data, {2'd2, 32'hA5A5_0003});
    step();
    chk("single_done", out_vld, 0);

    // backpressure: FIFO plus output register absorb 5 words
    out_ack = 1'b0;
    for (int i = 0; i < 5; i++) send(0, 32'h8BB0_0000 | 32'(i), 1'b1);
    chk("bp_ack_low", in_ack[0], 0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_vld_hold", out_vld, 1);
      chk("bp_data_hold", out_data, {2'd0, 32'h8BB0_0000});
      step();
    end
    out_ack = 1'b1;
    repeat (6) step();
    chk("bp_count", sb_q.size(), 0);
    step();
    chk("bp_idle", ap_idle, 1);

    // ap_start low: block input, keep draining
    out_ack = 1'b0;
    for (int i = 0; i < 3; i++) send(2, 32'hC0DE_0000 | 32'(i), 1'b1);
    ap_start = 1'b0;
    in_data[0*W +: W] = 32'hBAD0_0000;
    in_vld[0] = 1'b1;
    #1;
    chk("start_in_ack", in_ack, 0);
    chk("start_busy", ap_idle, 0);
    out_ack = 1'b1;
    for (int i = 0; i < 12 && ap_idle !== 1'b1; i++) step();
    chk("start_idle", ap_idle, 1);
    chk("start_count", sb_q.size(), 0);
    in_vld = '0;
    ap_start = 1'b1;
    step();

`ifdef STREAM_RR_MUX_PKT_LOCK_EN
    out_ack = 1'b0;
    send(0, 32'h0000_00A0, 1'b1);
    for (int i = 0; i < 4; i++) send(1, 32'h8000_01B0 | 32'(i), 1'b0);
    send(0, 32'h0000_00A1, 1'b0);
    send(0, 32'h8000_00A2, 1'b0);
    sb_q.push_back({2'd0, 32'h0000_00A1});
    sb_q.push_back({2'd0, 32'h8000_00A2});
    for (int i = 0; i < 4; i++) sb_q.push_back({2'd1, 32'h8000_01B0 | 32'(i)});
    out_ack = 1'b1;
    repeat (10) step();
    chk("pkt_count", sb_q.size(), 0);
`endif

    chk("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
